// File: rtl/irq_trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode interrupt/trap sequencer.
package trap_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, SLEEP = 2'd1, TRAP = 2'd2} state_e;

  localparam int MCAUSE_MEI     = 11;
  localparam int MCAUSE_MTI     = 7;
  localparam int MIP_MEIP       = 11;
  localparam int MIP_MTIP       = 7;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int NUM_IRQ = 2;
  localparam int IRQ_EXT = 0;
  localparam int IRQ_TMR = 1;
  localparam int CAUSE_W = 5;

  // External beats timer whenever both are enabled and pending.
  function automatic logic [CAUSE_W-1:0] sel_cause(input logic mei_en);
    return mei_en ? CAUSE_W'(MCAUSE_MEI) : CAUSE_W'(MCAUSE_MTI);
  endfunction
endpackage

// File: rtl/irq_trap_ctrl_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt level.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);
  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], i_async};
  end

  assign o_sync = r_chain[STAGES-1];
endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode IRQ sampling, arbitration, WFI sleep/wake, trap entry and MRET return
// sequencing beside the EX stage.
module irq_trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_irq,
  input  logic            tmr_irq,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_wfi,
  input  logic            ex_mret,
  input  logic            mem_busy,
  output logic [XLEN-1:0] mip_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            trap_we_o,
  output logic            mret_we_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o
);
  localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(32'h880);
  localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);

  logic [NUM_IRQ-1:0] w_irq_raw, w_irq_sync;
  logic [XLEN-1:0]    w_mip, w_masked, w_wfi_pc_inc;
  logic               w_pend, w_take, w_go, w_mei_en;

  state_e             r_state, w_state_nxt;
  logic [XLEN-1:0]    r_mepc, w_mepc_nxt;
  logic [XLEN-1:0]    r_wfi_pc, w_wfi_pc_nxt;
  logic [CAUSE_W-1:0] r_cause, w_cause_nxt;

  assign w_irq_raw = {tmr_irq, ext_irq};

  generate
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
      irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_async(w_irq_raw[g]),
        .o_sync (w_irq_sync[g])
      );
    end
  endgenerate

  always_comb begin
    w_mip           = '0;
    w_mip[MIP_MEIP] = w_irq_sync[IRQ_EXT];
    w_mip[MIP_MTIP] = w_irq_sync[IRQ_TMR];
  end

  assign mip_o        = w_mip;
  assign w_masked     = w_mip & mie_i & IRQ_MASK;
  assign w_pend       = |w_masked;
  assign w_take       = w_pend & mstatus_mie;
  assign w_mei_en     = w_masked[MIP_MEIP];
  assign w_go         = ex_valid & ~mem_busy;
  assign w_wfi_pc_inc = r_wfi_pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_mepc   <= '0;
      r_wfi_pc <= '0;
      r_cause  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mepc   <= w_mepc_nxt;
      r_wfi_pc <= w_wfi_pc_nxt;
      r_cause  <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mepc_nxt   = r_mepc;
    w_wfi_pc_nxt = r_wfi_pc;
    w_cause_nxt  = r_cause;
    case (r_state)
      RUN: begin
        // MRET outranks a pending IRQ so the restored MIE is seen next cycle.
        if (w_go && !ex_mret) begin
          if (w_take) begin
            w_state_nxt = TRAP;
            w_mepc_nxt  = ex_pc;
            w_cause_nxt = sel_cause(w_mei_en);
          end else if (ex_wfi) begin
            w_state_nxt  = SLEEP;
            w_wfi_pc_nxt = ex_pc;
          end
        end
      end
      SLEEP: begin
        if (w_pend) begin
          if (!mstatus_mie) begin
            w_state_nxt = RUN;
          end else if (!mem_busy) begin
            w_state_nxt = TRAP;
            w_mepc_nxt  = w_wfi_pc_inc;
            w_cause_nxt = sel_cause(w_mei_en);
          end
        end
      end
      TRAP:    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_o       = 1'b0;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    trap_we_o     = 1'b0;
    mret_we_o     = 1'b0;
    mepc_o        = '0;
    mcause_o      = '0;
    // Outputs are held at zero while reset is asserted so no partial CSR write escapes.
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (w_go && ex_mret) begin
            flush_o       = 1'b1;
            redirect_o    = 1'b1;
            redirect_pc_o = mepc_i & PC_ALIGN;
            mret_we_o     = 1'b1;
          end else if (w_go && !w_take && ex_wfi) begin
            stall_o = 1'b1;
          end
        end
        SLEEP: stall_o = 1'b1;
        TRAP: begin
          flush_o       = 1'b1;
          redirect_o    = 1'b1;
          redirect_pc_o = mtvec_i & PC_ALIGN;
          trap_we_o     = 1'b1;
          mepc_o        = r_mepc;
          mcause_o      = {1'b1, {(XLEN-1-CAUSE_W){1'b0}}, r_cause};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl: reset, IRQ trap, WFI sleep/wake, MRET priority, mem_busy deferral.
module tb_irq_trap_ctrl;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] MTVEC = 32'h0000_1000;

  logic            clk, rst, ext_irq, tmr_irq, mstatus_mie;
  logic [XLEN-1:0] mie_i, mtvec_i, mepc_i, ex_pc;
  logic            ex_valid, ex_wfi, ex_mret, mem_busy;
  logic [XLEN-1:0] mip_o, redirect_pc_o, mepc_o, mcause_o;
  logic            stall_o, flush_o, redirect_o, trap_we_o, mret_we_o;
  logic [4:0]      strb;

  int total = 0;
  int bad   = 0;

  irq_trap_ctrl #(.XLEN(XLEN), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ext_irq(ext_irq), .tmr_irq(tmr_irq),
    .mstatus_mie(mstatus_mie), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_wfi(ex_wfi), .ex_mret(ex_mret),
    .mem_busy(mem_busy), .mip_o(mip_o), .stall_o(stall_o), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .trap_we_o(trap_we_o),
    .mret_we_o(mret_we_o), .mepc_o(mepc_o), .mcause_o(mcause_o)
  );

  // {stall, flush, redirect, trap_we, mret_we}
  assign strb = {stall_o, flush_o, redirect_o, trap_we_o, mret_we_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drain();
    for (int i = 0; i < 3; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_irq = 0; tmr_irq = 0; mstatus_mie = 0; mie_i = '0;
    mtvec_i = MTVEC; mepc_i = '0; ex_valid = 0; ex_pc = '0; ex_wfi = 0;
    ex_mret = 0; mem_busy = 0;
    repeat (3) @(negedge clk);
    total++;
    if (strb !== 5'b0) begin bad++; $display("FAIL reset_strobes: got %b want %b", strb, 5'b0); end
    total++;
    if ({mip_o, mepc_o, mcause_o, redirect_pc_o} !== '0) begin
      bad++; $display("FAIL reset_data: mip=%h mepc=%h mcause=%h rpc=%h want 0", mip_o, mepc_o, mcause_o, redirect_pc_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ext_trap();
    mie_i = 32'h800; mstatus_mie = 1; ex_valid = 1; ex_pc = 32'h100; ext_irq = 1;
    @(negedge clk);
    total++;
    if (mip_o !== 32'h0) begin bad++; $display("FAIL ext_sync_lat: mip got %h want %h", mip_o, 32'h0); end
    @(negedge clk);
    total++;
    if (mip_o !== 32'h800 || strb !== 5'b0) begin
      bad++; $display("FAIL ext_mip: mip=%h strb=%b want 800 00000", mip_o, strb);
    end
    @(negedge clk);
    total++;
    if (strb !== 5'b01110 || mepc_o !== 32'h100 || mcause_o !== 32'h8000000B || redirect_pc_o !== MTVEC) begin
      bad++; $display("FAIL ext_trap: strb=%b mepc=%h mcause=%h rpc=%h want 01110 100 8000000b %h",
                      strb, mepc_o, mcause_o, redirect_pc_o, MTVEC);
    end
    mstatus_mie = 0; ext_irq = 0;
    @(negedge clk);
    total++;
    if (strb !== 5'b0) begin bad++; $display("FAIL ext_trap_pulse: got %b want %b", strb, 5'b0); end
    drain();
  endtask

  task automatic test_wfi_timer();
    mie_i = 32'h80; mstatus_mie = 1; ex_valid = 1; ex_pc = 32'h200; ex_wfi = 1;
    @(negedge clk);
    begin
      int held = 1;
      for (int i = 0; i < 20; i++) begin
        if (strb !== 5'b10000) held = 0;
        @(negedge clk);
      end
      total++;
      if (held != 1) begin bad++; $display("FAIL wfi_stall_held: got %0d want %0d", held, 1); end
    end
    tmr_irq = 1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (strb !== 5'b10000 || mip_o !== 32'h80) begin
      bad++; $display("FAIL wfi_pre_trap: strb=%b mip=%h want 10000 80", strb, mip_o);
    end
    @(negedge clk);
    total++;
    if (strb !== 5'b01110 || mepc_o !== 32'h204 || mcause_o !== 32'h80000007 || redirect_pc_o !== MTVEC) begin
      bad++; $display("FAIL wfi_trap: strb=%b mepc=%h mcause=%h rpc=%h want 01110 204 80000007 %h",
                      strb, mepc_o, mcause_o, redirect_pc_o, MTVEC);
    end
    mstatus_mie = 0; tmr_irq = 0; ex_wfi = 0; ex_valid = 0;
    drain();
  endtask

  task automatic test_wfi_wake_nomie();
    mstatus_mie = 0; mie_i = 32'h800; ex_valid = 1; ex_pc = 32'h300; ex_wfi = 1;
    @(negedge clk);
    total++;
    if (strb !== 5'b10000) begin bad++; $display("FAIL wake_stall_first: got %b want %b", strb, 5'b10000); end
    @(negedge clk);
    ext_irq = 1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (strb !== 5'b10000) begin bad++; $display("FAIL wake_cycle: got %b want %b", strb, 5'b10000); end
    @(negedge clk);
    ex_wfi = 0; ex_pc = 32'h304;
    #1;
    total++;
    if (strb !== 5'b0) begin bad++; $display("FAIL wake_resume: got %b want %b", strb, 5'b0); end
    @(negedge clk);
    total++;
    if (strb !== 5'b0) begin bad++; $display("FAIL wake_no_trap: got %b want %b", strb, 5'b0); end
  endtask

  task automatic test_mret_vs_irq();
    // ext_irq is still high and synchronised from the previous scenario.
    mstatus_mie = 1; ex_valid = 1; ex_mret = 1; ex_pc = 32'h3f0; mepc_i = 32'h402;
    #1;
    total++;
    if (strb !== 5'b01101 || redirect_pc_o !== 32'h400) begin
      bad++; $display("FAIL mret_first: strb=%b rpc=%h want 01101 400", strb, redirect_pc_o);
    end
    @(negedge clk);
    ex_mret = 0; ex_pc = 32'h400;
    #1;
    total++;
    if (strb !== 5'b0) begin bad++; $display("FAIL mret_pulse: got %b want %b", strb, 5'b0); end
    @(negedge clk);
    total++;
    if (strb !== 5'b01110 || mepc_o !== 32'h400 || mcause_o !== 32'h8000000B) begin
      bad++; $display("FAIL mret_then_trap: strb=%b mepc=%h mcause=%h want 01110 400 8000000b", strb, mepc_o, mcause_o);
    end
    mstatus_mie = 0; ext_irq = 0; ex_valid = 0;
    drain();
  endtask

  task automatic test_busy_priority();
    ext_irq = 1; tmr_irq = 1; mie_i = 32'h880; mstatus_mie = 1;
    ex_valid = 1; ex_pc = 32'h500; mem_busy = 1;
    begin
      int quiet = 1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (strb !== 5'b0) quiet = 0;
      end
      total++;
      if (quiet != 1) begin bad++; $display("FAIL busy_defer: got %0d want %0d", quiet, 1); end
    end
    total++;
    if (mip_o !== 32'h880) begin bad++; $display("FAIL busy_mip: got %h want %h", mip_o, 32'h880); end
    mem_busy = 0;
    @(negedge clk);
    total++;
    if (strb !== 5'b01110 || mcause_o !== 32'h8000000B || mepc_o !== 32'h500) begin
      bad++; $display("FAIL busy_trap: strb=%b mcause=%h mepc=%h want 01110 8000000b 500", strb, mcause_o, mepc_o);
    end
    mstatus_mie = 0; ext_irq = 0; tmr_irq = 0; ex_valid = 0;
    drain();
  endtask

  task automatic test_wrap_busy_sleep();
    mstatus_mie = 1; mie_i = 32'h800; ex_valid = 1; ex_wfi = 1; ex_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    ext_irq = 1; mem_busy = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (strb !== 5'b10000) begin bad++; $display("FAIL sleep_busy_hold: got %b want %b", strb, 5'b10000); end
    mem_busy = 0;
    @(negedge clk);
    total++;
    if (strb !== 5'b01110 || mepc_o !== 32'h0 || mcause_o !== 32'h8000000B) begin
      bad++; $display("FAIL wrap_trap: strb=%b mepc=%h mcause=%h want 01110 0 8000000b", strb, mepc_o, mcause_o);
    end
    mstatus_mie = 0; ext_irq = 0; ex_wfi = 0; ex_valid = 0;
    drain();
  endtask

  task automatic test_reset_sleep();
    mie_i = '0; ex_valid = 1; ex_wfi = 1; ex_pc = 32'h600;
    @(negedge clk);
    total++;
    if (strb !== 5'b10000) begin bad++; $display("FAIL rst_sleep_enter: got %b want %b", strb, 5'b10000); end
    rst = 1;
    #1;
    total++;
    if (strb !== 5'b0) begin bad++; $display("FAIL rst_sleep_immediate: got %b want %b", strb, 5'b0); end
    @(negedge clk);
    ex_wfi = 0; ex_valid = 0; rst = 0;
    #1;
    total++;
    if (strb !== 5'b0 || mip_o !== 32'h0) begin
      bad++; $display("FAIL rst_sleep_run: strb=%b mip=%h want 00000 0", strb, mip_o);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ext_trap();
    test_wfi_timer();
    test_wfi_wake_nomie();
    test_mret_vs_irq();
    test_busy_priority();
    test_wrap_busy_sleep();
    test_reset_sleep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
